// File: rtl/tc_out_collector.sv
// Accumulates ITER_K passes of M signed N-lane rows from tc_core into a tile,
// then drains the finished tile one row per cycle over valid/ready.
module tc_out_collector #(
   parameter int unsigned M       = 16,
   parameter int unsigned N       = 16,
   parameter int unsigned ITER_K  = 2,
   parameter int unsigned DW_DATA = 8,
   parameter int unsigned DW_ACC  = 16,
   localparam int unsigned RW     = (M > 1) ? $clog2(M) : 1,
   localparam int unsigned PW     = (ITER_K > 1) ? $clog2(ITER_K) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DW_DATA-1:0]  in_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*DW_ACC-1:0]   out_data,
   output logic [RW-1:0]         out_row,
   output logic                  busy,
   output logic                  done
);

   if (ITER_K < 1) begin : g_bad_iter_k
      $error("tc_out_collector: ITER_K must be at least 1");
   end
   if (DW_ACC < DW_DATA) begin : g_bad_dw_acc
      $error("tc_out_collector: DW_ACC must be at least DW_DATA");
   end

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain
   } state_e;

   state_e              r_state;
   logic [RW-1:0]       r_row_cnt;
   logic [PW-1:0]       r_pass_cnt;
   logic                r_out_valid;
   logic [N*DW_ACC-1:0] r_out_data;
   logic [RW-1:0]       r_out_row;
   logic                r_done;

   logic [DW_ACC-1:0]   r_acc [M][N];

   logic                w_in_xfer;
   logic                w_acc_we;
   logic                w_last_row;
   logic                w_last_pass;
   logic                w_out_xfer;
   logic [RW-1:0]       w_drain_idx;
   logic [DW_ACC-1:0]   w_acc_row [N];
   logic [N*DW_ACC-1:0] w_drain_data;

   assign in_ready    = (r_state != StDrain);
   assign busy        = (r_state != StIdle);
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_row     = r_out_row;
   assign done        = r_done;

   assign w_in_xfer   = in_valid & in_ready;
   assign w_acc_we    = w_in_xfer & ~flush;
   assign w_last_row  = (r_row_cnt == RW'(M - 1));
   assign w_last_pass = (r_pass_cnt == PW'(ITER_K - 1));
   assign w_out_xfer  = r_out_valid & out_ready;

   // The first DRAIN cycle loads the current row; later loads fetch the next one.
   assign w_drain_idx = r_out_valid ? (r_row_cnt + RW'(1)) : r_row_cnt;

   always_comb begin
      for (int j = 0; j < int'(N); j++) begin
         w_acc_row[j] = DW_ACC'($signed(in_data[j*DW_DATA +: DW_DATA]));
         if (r_pass_cnt != '0) begin
            w_acc_row[j] = r_acc[r_row_cnt][j] + w_acc_row[j];
         end
      end
   end

   always_comb begin
      w_drain_data = '0;
      for (int j = 0; j < int'(N); j++) begin
         w_drain_data[j*DW_ACC +: DW_ACC] = r_acc[w_drain_idx][j];
      end
   end

   // Tile storage needs no reset: pass 0 overwrites every row before it is read.
   always_ff @(posedge clk) begin
      if (w_acc_we) begin
         r_acc[r_row_cnt] <= w_acc_row;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_row_cnt   <= '0;
         r_pass_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_row   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state     <= StIdle;
            r_row_cnt   <= '0;
            r_pass_cnt  <= '0;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               StIdle, StAccum: begin
                  if (w_in_xfer) begin
                     r_state <= StAccum;
                     if (w_last_row) begin
                        r_row_cnt <= '0;
                        if (w_last_pass) begin
                           r_pass_cnt <= '0;
                           r_state    <= StDrain;
                        end else begin
                           r_pass_cnt <= r_pass_cnt + PW'(1);
                        end
                     end else begin
                        r_row_cnt <= r_row_cnt + RW'(1);
                     end
                  end
               end
               StDrain: begin
                  if (!r_out_valid) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_drain_data;
                     r_out_row   <= w_drain_idx;
                  end else if (w_out_xfer) begin
                     if (w_last_row) begin
                        r_out_valid <= 1'b0;
                        r_row_cnt   <= '0;
                        r_done      <= 1'b1;
                        r_state     <= StIdle;
                     end else begin
                        r_row_cnt  <= w_drain_idx;
                        r_out_data <= w_drain_data;
                        r_out_row  <= w_drain_idx;
                     end
                  end
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tc_out_collector.sv
// Directed bench for tc_out_collector: one default instance plus an 8-bit
// accumulator instance driven by the same stimulus.
module tb_tc_out_collector;

   localparam int M = 16;
   localparam int N = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic [N*8-1:0]    in_data;
   logic              flush;
   logic              out_ready;

   logic              in_ready, out_valid, busy, done;
   logic [N*16-1:0]   out_data;
   logic [3:0]        out_row;

   logic              in_ready8, out_valid8, busy8, done8;
   logic [N*8-1:0]    out_data8;
   logic [3:0]        out_row8;

   logic [N*16-1:0]   exp_row  [M];
   logic [N*8-1:0]    exp8_row [M];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tc_out_collector u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .busy      (busy),
      .done      (done)
   );

   tc_out_collector #(.DW_ACC(8)) u_dut8 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .out_data  (out_data8),
      .out_row   (out_row8),
      .busy      (busy8),
      .done      (done8)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Lane value fed for a given mode/pass/row/lane.
   function automatic logic [7:0] lane_val(input int mode, input int p, input int r, input int j);
      case (mode)
         0:       return 8'h01;
         1:       return 8'h80;
         2:       return (p == 0) ? 8'(r) : 8'(j);
         3:       return 8'h7F;
         4:       return 8'h03;
         default: return 8'hFF;
      endcase
   endfunction

   // Hand-derived tile results for each mode (two passes summed).
   task automatic set_exp(input int mode);
      logic [15:0] v16;
      logic [7:0]  v8;
      for (int r = 0; r < M; r++) begin
         for (int j = 0; j < N; j++) begin
            case (mode)
               0:       begin v16 = 16'h0002; v8 = 8'h02; end
               1:       begin v16 = 16'hFF00; v8 = 8'h00; end
               2:       begin v16 = 16'(r + j); v8 = 8'(r + j); end
               3:       begin v16 = 16'h00FE; v8 = 8'hFE; end
               4:       begin v16 = 16'h0006; v8 = 8'h06; end
               default: begin v16 = 16'hFFFE; v8 = 8'hFE; end
            endcase
            exp_row[r][j*16 +: 16] = v16;
            exp8_row[r][j*8 +: 8]  = v8;
         end
      end
   endtask

   task automatic send_row(input int mode, input int p, input int r);
      for (int j = 0; j < N; j++) in_data[j*8 +: 8] = lane_val(mode, p, r, j);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int mode);
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < M; r++) send_row(mode, p, r);
      end
      in_valid = 1'b0;
   endtask

   // Drains up to stop_at rows; returns early (no done expected) if stop_at < M.
   task automatic drain(input string name, input bit toggle, input bit poke, input int stop_at);
      int  idx = 0;
      int  cyc = 0;
      bit  hs;
      chk({name, "_lat_t1_valid"}, 256'(out_valid), 256'(0));
      chk({name, "_drain_in_ready"}, 256'(in_ready), 256'(0));
      out_ready = 1'b1;
      while (cyc < 200) begin
         hs = out_valid && out_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (hs) idx++;
         if (idx == stop_at) break;
         if (cyc == 1) chk({name, "_lat_row0"}, 256'(out_valid), 256'(1));
         if (out_valid) begin
            chk({name, "_row"}, 256'(out_row), 256'(idx));
            chk({name, "_data"}, 256'(out_data), 256'(exp_row[idx]));
            chk({name, "_data8"}, 256'(out_data8), 256'(exp8_row[idx]));
            chk({name, "_done_low"}, 256'(done), 256'(0));
         end
         if (poke) chk({name, "_poke_in_ready"}, 256'(in_ready), 256'(0));
         out_ready = toggle ? ~out_ready : 1'b1;
         in_valid  = poke ? cyc[0] : 1'b0;
         in_data   = {$urandom, $urandom, $urandom, $urandom};
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({name, "_rows_done"}, 256'(idx), 256'(stop_at));
      if (stop_at == M) begin
         chk({name, "_done_pulse"}, 256'(done), 256'(1));
         chk({name, "_done8_pulse"}, 256'(done8), 256'(1));
         chk({name, "_end_valid"}, 256'(out_valid), 256'(0));
         @(posedge clk);
         #1;
         chk({name, "_done_once"}, 256'(done), 256'(0));
         chk({name, "_idle"}, 256'(busy), 256'(0));
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 256'(in_ready), 256'(1));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_data", 256'(out_data), 256'(0));
      chk("rst_out_row", 256'(out_row), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: all-ones tile
      set_exp(0);
      feed(0);
      chk("t1_busy", 256'(busy), 256'(1));
      drain("t1", 1'b0, 1'b0, M);

      // 2a: 0x80 + 0x80 sign-extended
      set_exp(1);
      feed(1);
      drain("t2a", 1'b0, 1'b0, M);

      // 2b + 4: r+j pattern drained with stalls and ignored in_valid pulses
      set_exp(2);
      feed(2);
      drain("t4", 1'b1, 1'b1, M);

      // 3: wrap with no saturation
      set_exp(3);
      feed(3);
      drain("t3", 1'b0, 1'b0, M);

      // 5: reset mid-drain after row 5, then a fresh tile
      set_exp(0);
      feed(0);
      drain("t5a", 1'b0, 1'b0, 6);
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", 256'(out_valid), 256'(0));
      chk("t5_rst_busy", 256'(busy), 256'(0));
      chk("t5_rst_in_ready", 256'(in_ready), 256'(1));
      chk("t5_rst_done", 256'(done), 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_no_done", 256'(done), 256'(0));
      set_exp(4);
      feed(4);
      drain("t5b", 1'b0, 1'b0, M);

      // 6: flush coincident with an ACCUM transfer
      for (int r = 0; r < 3; r++) send_row(5, 0, r);
      in_data  = {N{8'h55}};
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t6_flush_idle", 256'(busy), 256'(0));
      chk("t6_flush_valid", 256'(out_valid), 256'(0));
      chk("t6_flush_ready", 256'(in_ready), 256'(1));
      set_exp(5);
      feed(5);
      drain("t6", 1'b0, 1'b0, M);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
